// File: rtl/alu_pkg.sv
// Shared opcode encoding and saturation helper for the pipelined ALU.
package alu_pkg;

    // Widest operand the clamp helper supports. The helper takes a
    // sign-extended (nIO+1)-bit sum carried in this fixed width.
    localparam int MAX_W = 64;
    localparam int IDX_W = $clog2(MAX_W);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MAX = 3'd2,
        OP_MIN = 3'd3,
        OP_SHL = 3'd4,
        OP_SAR = 3'd5,
        OP_ACC = 3'd6,
        OP_CLR = 3'd7
    } op_e;

    // Clamp a (w+1)-bit signed sum, sign-extended to MAX_W, into the
    // signed w-bit range. Bits w and w-1 disagree exactly when the sum
    // does not fit in w bits; bit w then gives the overflow direction.
    function automatic logic [MAX_W-1:0] sat_clamp(input logic [MAX_W-1:0] v,
                                                   input logic [IDX_W-1:0] w);
        logic [MAX_W-1:0] max_pos;
        max_pos = (MAX_W'(1) << (w - IDX_W'(1))) - MAX_W'(1);
        if (v[w] == v[w - IDX_W'(1)])
            sat_clamp = v;
        else if (v[w])
            sat_clamp = ~max_pos;
        else
            sat_clamp = max_pos;
    endfunction

endpackage

// File: rtl/alu_sat_addsub.sv
// Signed add/subtract with overflow detect and optional saturation.
module alu_sat_addsub
    import alu_pkg::*;
#(
    parameter int nIO = 8,
    parameter int SAT = 0
) (
    input  logic [nIO-1:0] a,
    input  logic [nIO-1:0] b,
    input  logic           sub,
    output logic [nIO-1:0] s,
    output logic           ov
);

    logic [nIO:0]     sum;
    logic [MAX_W-1:0] clamped;

    // One extra bit holds the exact result of any nIO-bit add or subtract.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        sum = sub ? ({a[nIO-1], a} - {b[nIO-1], b})
                  : ({a[nIO-1], a} + {b[nIO-1], b});
        ov      = sum[nIO] ^ sum[nIO-1];
        clamped = sat_clamp(MAX_W'(signed'(sum)), IDX_W'(nIO));
        s       = (SAT != 0) ? nIO'(clamped) : sum[nIO-1:0];
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, signed accumulator and
// sticky overflow flag. One output register stage, one-cycle latency.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int nIO     = 8,
    parameter int nOP     = 3,
    parameter int SHL_AMT = 2,
    parameter int SHR_AMT = 3,
    parameter int SAT     = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [nIO-1:0] A,
    input  logic [nIO-1:0] B,
    input  logic [nOP-1:0] OP,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [nIO-1:0] Z,
    output logic           OV,
    output logic           ov_sticky,
    output logic [nIO-1:0] acc
);

    logic           accept;
    logic [nIO-1:0] addsub_s;
    logic           addsub_ov;
    logic [nIO-1:0] acc_s;
    logic           acc_ov;
    logic [nIO-1:0] z_next;
    logic           ov_next;

    // The output register can take a new result when empty or draining.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    alu_sat_addsub #(.nIO(nIO), .SAT(SAT)) u_addsub (
        .a   (A),
        .b   (B),
        .sub (OP == nOP'(OP_SUB)),
        .s   (addsub_s),
        .ov  (addsub_ov)
    );

    alu_sat_addsub #(.nIO(nIO), .SAT(SAT)) u_acc (
        .a   (acc),
        .b   (A),
        .sub (1'b0),
        .s   (acc_s),
        .ov  (acc_ov)
    );

    // Select the result and its overflow flag for the current opcode.
    always_comb begin
        z_next  = '0;
        ov_next = 1'b0;
        case (OP)
            nOP'(OP_ADD),
            nOP'(OP_SUB): begin
                z_next  = addsub_s;
                ov_next = addsub_ov;
            end
            nOP'(OP_MAX): z_next = ($signed(A) > $signed(B)) ? A : B;
            nOP'(OP_MIN): z_next = ($signed(A) < $signed(B)) ? A : B;
            nOP'(OP_SHL): z_next = A <<< SHL_AMT;
            nOP'(OP_SAR): z_next = $unsigned($signed(B) >>> SHR_AMT);
            nOP'(OP_ACC): begin
                z_next  = acc_s;
                ov_next = acc_ov;
            end
            default:      z_next = '0;
        endcase
    end

    // Output register, accumulator and sticky flag; rst overrides everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            out_valid <= 1'b0;
            Z         <= '0;
            OV        <= 1'b0;
            ov_sticky <= 1'b0;
            acc       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            Z         <= z_next;
            OV        <= ov_next;
            if (OP == nOP'(OP_CLR))
                ov_sticky <= 1'b0;
            else if (ov_next)
                ov_sticky <= 1'b1;
            if (OP == nOP'(OP_ACC))
                acc <= acc_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: one wrapping and one saturating instance
// driven by the same stimulus.
module tb_alu_pipe;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;

    logic       in_ready0, out_valid0, ov0, sticky0;
    logic [7:0] z0, acc0;
    logic       in_ready1, out_valid1, ov1, sticky1;
    logic [7:0] z1, acc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_pipe #(.nIO(8), .nOP(3), .SHL_AMT(2), .SHR_AMT(3), .SAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .A(a), .B(b), .OP(op), .out_valid(out_valid0), .out_ready(out_ready),
        .Z(z0), .OV(ov0), .ov_sticky(sticky0), .acc(acc0)
    );

    alu_pipe #(.nIO(8), .nOP(3), .SHL_AMT(2), .SHR_AMT(3), .SAT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .A(a), .B(b), .OP(op), .out_valid(out_valid1), .out_ready(out_ready),
        .Z(z1), .OV(ov1), .ov_sticky(sticky1), .acc(acc1)
    );

    typedef struct {
        op_e        op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] z_wrap;
        logic       ov_wrap;
        logic [7:0] z_sat;
        logic       ov_sat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_e o, input logic [7:0] va, input logic [7:0] vb);
        in_valid = 1'b1;
        op       = o;
        a        = va;
        b        = vb;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{OP_ADD, 8'd100, 8'd50,  8'h96, 1'b1, 8'h7F, 1'b1};
        vecs[1]  = '{OP_SUB, 8'h9C,  8'd50,  8'h6A, 1'b1, 8'h80, 1'b1};
        vecs[2]  = '{OP_ADD, 8'd3,   8'd4,   8'h07, 1'b0, 8'h07, 1'b0};
        vecs[3]  = '{OP_SUB, 8'd5,   8'd9,   8'hFC, 1'b0, 8'hFC, 1'b0};
        vecs[4]  = '{OP_MAX, 8'hFD,  8'hC0,  8'hFD, 1'b0, 8'hFD, 1'b0};
        vecs[5]  = '{OP_MIN, 8'hFD,  8'hC0,  8'hC0, 1'b0, 8'hC0, 1'b0};
        vecs[6]  = '{OP_SHL, 8'hFD,  8'hC0,  8'hF4, 1'b0, 8'hF4, 1'b0};
        vecs[7]  = '{OP_SAR, 8'hFD,  8'hC0,  8'hF8, 1'b0, 8'hF8, 1'b0};
        vecs[8]  = '{OP_ADD, 8'h80,  8'hFF,  8'h7F, 1'b1, 8'h80, 1'b1};
        vecs[9]  = '{OP_SUB, 8'h7F,  8'hFF,  8'h80, 1'b1, 8'h7F, 1'b1};
        vecs[10] = '{OP_ADD, 8'h80,  8'h7F,  8'hFF, 1'b0, 8'hFF, 1'b0};
        vecs[11] = '{OP_SHL, 8'h40,  8'h00,  8'h00, 1'b0, 8'h00, 1'b0};
        vecs[12] = '{OP_SAR, 8'h00,  8'h7F,  8'h0F, 1'b0, 8'h0F, 1'b0};
        vecs[13] = '{OP_CLR, 8'd5,   8'd5,   8'h00, 1'b0, 8'h00, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        op        = OP_ADD;
        tick();
        tick();
        check("reset out_valid", 16'(out_valid0), 16'd0);
        check("reset Z", 16'(z0), 16'd0);
        check("reset OV", 16'(ov0), 16'd0);
        check("reset sticky", 16'(sticky0), 16'd0);
        check("reset acc", 16'(acc0), 16'd0);
        check("reset in_ready", 16'(in_ready0), 16'd1);
        rst = 1'b0;

        // Wrapping overflow sets the sticky flag; CLR clears it.
        drive(OP_ADD, 8'd100, 8'd50);
        tick();
        check("add ovf out_valid", 16'(out_valid0), 16'd1);
        check("add ovf Z", 16'(z0), 16'h96);
        check("add ovf OV", 16'(ov0), 16'd1);
        check("add ovf sticky", 16'(sticky0), 16'd1);
        drive(OP_CLR, 8'd0, 8'd0);
        tick();
        check("clr Z", 16'(z0), 16'd0);
        check("clr OV", 16'(ov0), 16'd0);
        check("clr sticky", 16'(sticky0), 16'd0);

        // Back-to-back table, one result per cycle on both instances.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            check($sformatf("vec%0d out_valid", i), 16'(out_valid0), 16'd1);
            check($sformatf("vec%0d Z wrap", i), 16'(z0), 16'(vecs[i].z_wrap));
            check($sformatf("vec%0d OV wrap", i), 16'(ov0), 16'(vecs[i].ov_wrap));
            check($sformatf("vec%0d Z sat", i), 16'(z1), 16'(vecs[i].z_sat));
            check($sformatf("vec%0d OV sat", i), 16'(ov1), 16'(vecs[i].ov_sat));
        end
        check("table end sticky", 16'(sticky0), 16'd0);
        check("table end acc", 16'(acc0), 16'd0);

        // Back-to-back accumulation.
        drive(OP_ACC, 8'd10, 8'd0);
        tick();
        check("acc1 Z", 16'(z0), 16'd10);
        drive(OP_ACC, 8'd20, 8'd0);
        tick();
        check("acc2 Z", 16'(z0), 16'd30);
        drive(OP_ACC, 8'hFB, 8'd0);
        tick();
        check("acc3 Z", 16'(z0), 16'd25);
        check("acc3 acc", 16'(acc0), 16'd25);
        check("acc3 OV", 16'(ov0), 16'd0);
        drive(OP_ADD, 8'd1, 8'd1);
        tick();
        check("add after acc Z", 16'(z0), 16'd2);
        check("add after acc acc", 16'(acc0), 16'd25);

        // Idle drain.
        in_valid = 1'b0;
        tick();
        check("drain out_valid", 16'(out_valid0), 16'd0);
        check("drain acc", 16'(acc0), 16'd25);

        // Backpressure: result held, second op waits.
        out_ready = 1'b0;
        drive(OP_ADD, 8'd1, 8'd2);
        tick();
        check("bp first Z", 16'(z0), 16'd3);
        check("bp first out_valid", 16'(out_valid0), 16'd1);
        drive(OP_SUB, 8'd9, 8'd4);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp hold%0d in_ready", i), 16'(in_ready0), 16'd0);
            tick();
            check($sformatf("bp hold%0d Z", i), 16'(z0), 16'd3);
            check($sformatf("bp hold%0d out_valid", i), 16'(out_valid0), 16'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 16'(in_ready0), 16'd1);
        tick();
        check("bp second Z", 16'(z0), 16'd5);
        check("bp second out_valid", 16'(out_valid0), 16'd1);
        in_valid = 1'b0;
        tick();
        check("bp drain out_valid", 16'(out_valid0), 16'd0);

        // Reset with a held result, acc=25 and sticky set.
        drive(OP_ADD, 8'd100, 8'd50);
        tick();
        drive(OP_ACC, 8'd0, 8'd0);
        tick();
        out_ready = 1'b0;
        check("pre-rst out_valid", 16'(out_valid0), 16'd1);
        check("pre-rst sticky", 16'(sticky0), 16'd1);
        check("pre-rst acc", 16'(acc0), 16'd25);
        drive(OP_ACC, 8'd7, 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("rst out_valid", 16'(out_valid0), 16'd0);
        check("rst acc", 16'(acc0), 16'd0);
        check("rst sticky", 16'(sticky0), 16'd0);
        check("rst Z", 16'(z0), 16'd0);

        // Accumulator overflow: wrap vs clamp, and clamped acc carried forward.
        drive(OP_ACC, 8'd100, 8'd0);
        tick();
        drive(OP_ACC, 8'd100, 8'd0);
        tick();
        check("accovf Z wrap", 16'(z0), 16'hC8);
        check("accovf OV wrap", 16'(ov0), 16'd1);
        check("accovf Z sat", 16'(z1), 16'h7F);
        check("accovf acc sat", 16'(acc1), 16'h7F);
        check("accovf sticky sat", 16'(sticky1), 16'd1);
        drive(OP_ACC, 8'h80, 8'd0);
        tick();
        check("accneg Z wrap", 16'(z0), 16'h48);
        check("accneg OV wrap", 16'(ov0), 16'd1);
        check("accneg Z sat", 16'(z1), 16'hFF);
        check("accneg OV sat", 16'(ov1), 16'd0);
        check("accneg acc sat", 16'(acc1), 16'hFF);
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
